spi_flash_reader: RTL and testbench

SPI_FLASH_READER -- requirements
Module: spi_flash_reader

---
 rtl/spi_flash_reader.sv | 151 +++++++++++++++
 tb/tb_spi_flash_reader.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_reader.sv
// rtl/spi_flash_reader.sv - SPI NOR flash 32-bit word reader (FAST_READ 0x0B when SPI_FLASH_FAST_READ_EN is defined, else READ 0x03)
module spi_flash_reader #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    DATA,
    GAP
  } state_t;

`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] READ_CMD   = 8'h0B;
  localparam logic [6:0] NBITS      = 7'd72;
  localparam logic [6:0] DUMMY_LAST = 7'd39;
  localparam state_t     AFTER_ADDR = DUMMY;
`else
  localparam logic [7:0] READ_CMD   = 8'h03;
  localparam logic [6:0] NBITS      = 7'd64;
  localparam state_t     AFTER_ADDR = DATA;
`endif

  // Bit indices (frame-relative) of the last bit in each phase
  localparam logic [6:0] CMD_LAST  = 7'd7;
  localparam logic [6:0] ADDR_LAST = 7'd31;
  localparam logic [6:0] DATA_LAST = NBITS - 7'd1;

  // div_cnt counts within one SCK half-period, and across the whole GAP,
  // so it is sized for 2*CLK_DIV-1 with CLK_DIV up to 255
  localparam logic [8:0] PHASE_LAST = 9'(CLK_DIV - 1);
  localparam logic [8:0] GAP_LAST   = 9'(2 * CLK_DIV - 1);

  state_t      state;
  logic [8:0]  div_cnt;
  logic [6:0]  bit_cnt;
  logic [31:0] tx_shift;
  logic [31:0] rx_shift;
  logic        phase_done;

  // Last cycle of the current SCK half-period
  assign phase_done = (div_cnt == PHASE_LAST);

  // Frame sequencer: SCK generation, MOSI shift-out, MISO shift-in, response
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= 32'd0;
      spi_cs_n  <= 1'b1;
      spi_sck   <= 1'b0;
      spi_mosi  <= 1'b0;
      div_cnt   <= 9'd0;
      bit_cnt   <= 7'd0;
      tx_shift  <= 32'd0;
      rx_shift  <= 32'd0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            state     <= CMD;
            req_ready <= 1'b0;
            spi_cs_n  <= 1'b0;
            // First bit goes out right away; the rest wait in tx_shift
            spi_mosi  <= READ_CMD[7];
            tx_shift  <= {READ_CMD[6:0], req_addr, 1'b0};
            div_cnt   <= 9'd0;
            bit_cnt   <= 7'd0;
            rx_shift  <= 32'd0;
          end
        end

        GAP: begin
          if (div_cnt == GAP_LAST) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            div_cnt   <= 9'd0;
          end else begin
            div_cnt <= div_cnt + 9'd1;
          end
        end

        default: begin
          if (!phase_done) begin
            div_cnt <= div_cnt + 9'd1;
          end else begin
            div_cnt <= 9'd0;
            if (!spi_sck) begin
              // Rising SCK edge: the flash data is stable here
              spi_sck <= 1'b1;
              if (state == DATA) begin
                rx_shift <= {rx_shift[30:0], spi_miso};
              end
            end else begin
              // Falling SCK edge closes the bit; MOSI may change now.
              // tx_shift empties to zero, so MOSI idles low after ADDR.
              spi_sck  <= 1'b0;
              spi_mosi <= tx_shift[31];
              tx_shift <= {tx_shift[30:0], 1'b0};
              bit_cnt  <= bit_cnt + 7'd1;
              case (state)
                CMD: begin
                  if (bit_cnt == CMD_LAST) state <= ADDR;
                end
                ADDR: begin
                  if (bit_cnt == ADDR_LAST) state <= AFTER_ADDR;
                end
`ifdef SPI_FLASH_FAST_READ_EN
                DUMMY: begin
                  if (bit_cnt == DUMMY_LAST) state <= DATA;
                end
`endif
                DATA: begin
                  if (bit_cnt == DATA_LAST) begin
                    state     <= GAP;
                    spi_cs_n  <= 1'b1;
                    bit_cnt   <= 7'd0;
                    rsp_valid <= 1'b1;
                    // Bytes arrived first-to-last in rx_shift[31:24]..[7:0];
                    // the first byte belongs in the low lane
                    rsp_data  <= {rx_shift[7:0], rx_shift[15:8],
                                  rx_shift[23:16], rx_shift[31:24]};
                  end
                end
                default: begin
                end
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// tb/tb_spi_flash_reader.sv - randomized self-checking bench for spi_flash_reader with a byte-array flash model
module tb_spi_flash_reader;

`ifdef SPI_FLASH_FAST_READ_EN
  localparam int         CLK_DIV  = 2;
  localparam int         NBITS    = 72;
  localparam logic [7:0] EXP_CMD  = 8'h0B;
  localparam int         DIR_LAT  = 289;
`else
  localparam int         CLK_DIV  = 1;
  localparam int         NBITS    = 64;
  localparam logic [7:0] EXP_CMD  = 8'h03;
  localparam int         DIR_LAT  = 129;
`endif
  localparam int CMD_BITS = NBITS - 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [23:0] req_addr = 24'd0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        spi_cs_n;
  logic        spi_sck;
  logic        spi_mosi;
  logic        spi_miso = 1'b0;

  spi_flash_reader #(.CLK_DIV(CLK_DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .spi_cs_n  (spi_cs_n),
    .spi_sck   (spi_sck),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0] mem [256];

  function automatic logic [31:0] model_word(input logic [23:0] a);
    return {mem[8'(a + 24'd3)], mem[8'(a + 24'd2)], mem[8'(a + 24'd1)], mem[8'(a)]};
  endfunction

  int          acc_count = 0;
  int          rsp_count = 0;
  int          age = 0;
  int          rises = 0;
  int          hi_run = 0;
  int          phase_run = 0;
  int          phase_bad = 0;
  int          mosi_bad = 0;
  int          mode_bad = 0;
  int          hold_bad = 0;
  int          last_latency = 0;
  bit          tracking = 1'b0;
  bit          frame_valid = 1'b0;
  bit          have_prev = 1'b0;
  logic [23:0] exp_addr = 24'd0;
  logic [23:0] flash_addr = 24'd0;
  logic [31:0] frame_bits = 32'd0;
  logic [31:0] last_rsp = 32'd0;
  logic        prev_cs = 1'b1;
  logic        prev_sck = 1'b0;
  logic        prev_mosi = 1'b0;

  // Monitor, scoreboard and flash model, all sampled mid-cycle
  always @(negedge clk) begin
    int         k;
    logic [7:0] b;
    if (rst) begin
      tracking    = 1'b0;
      frame_valid = 1'b0;
      have_prev   = 1'b0;
      last_rsp    = 32'd0;
    end else begin
      if (tracking) age++;
      if (rsp_valid) begin
        rsp_count++;
        check_eq("rsp_expected", tracking, 1);
        if (tracking) begin
          last_latency = age;
          check_eq("latency", age, 2 * CLK_DIV * NBITS + 1);
          check_eq("rsp_data", rsp_data, model_word(exp_addr));
          tracking = 1'b0;
        end
        last_rsp = rsp_data;
      end else if (rsp_data !== last_rsp) begin
        hold_bad++;
      end

      if (req_valid && req_ready) begin
        check_eq("accept_idle", tracking, 0);
        acc_count++;
        tracking = 1'b1;
        age      = 0;
        exp_addr = req_addr;
      end

      if (prev_cs === 1'b1 && spi_cs_n === 1'b0) begin
        if (have_prev) check_eq("cs_gap", hi_run >= 2 * CLK_DIV + 1, 1);
        frame_valid = 1'b1;
        rises       = 0;
        frame_bits  = 32'd0;
        mosi_bad    = 0;
        mode_bad    = 0;
        phase_run   = 1;
        phase_bad   = (spi_sck !== 1'b0) ? 1 : 0;
      end else if (frame_valid && spi_cs_n === 1'b0) begin
        if (spi_sck === prev_sck) begin
          phase_run++;
        end else begin
          if (phase_run != CLK_DIV) phase_bad++;
          phase_run = 1;
        end
        if (prev_sck === 1'b0 && spi_sck === 1'b1) begin
          rises++;
          if (rises <= 32) frame_bits = {frame_bits[30:0], spi_mosi};
          else if (spi_mosi !== 1'b0) mosi_bad++;
          if (rises == 32) flash_addr = frame_bits[23:0];
        end
        if (spi_sck === 1'b1 && spi_mosi !== prev_mosi) mode_bad++;
      end else if (frame_valid && prev_cs === 1'b0 && spi_cs_n === 1'b1) begin
        if (phase_run != CLK_DIV) phase_bad++;
        check_eq("sck_rises", rises, NBITS);
        check_eq("cmd", frame_bits[31:24], EXP_CMD);
        check_eq("addr", frame_bits[23:0], exp_addr);
        check_eq("mosi_zero", mosi_bad, 0);
        check_eq("mode0", mode_bad, 0);
        check_eq("sck_phase", phase_bad, 0);
        check_eq("sck_end_low", spi_sck, 0);
        frame_valid = 1'b0;
        have_prev   = 1'b1;
        hi_run      = 0;
      end
      if (spi_cs_n === 1'b1) hi_run++;

      // Flash shifts out on SCK low; junk outside DATA must be ignored
      if (frame_valid && spi_cs_n === 1'b0 && spi_sck === 1'b0) begin
        if (rises >= CMD_BITS && rises < NBITS) begin
          k = rises - CMD_BITS;
          b = mem[8'(flash_addr + 24'(k / 8))];
          spi_miso = b[7 - (k % 8)];
        end else begin
          spi_miso = 1'($urandom_range(0, 1));
        end
      end else if (!frame_valid) begin
        spi_miso = 1'($urandom_range(0, 1));
      end
    end
    prev_cs   = spi_cs_n;
    prev_sck  = spi_sck;
    prev_mosi = spi_mosi;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [23:0] a, input bit hold);
    int n0;
    n0 = acc_count;
    req_valid = 1'b1;
    req_addr  = a;
    for (int i = 0; i < 4000 && acc_count == n0; i++) tick();
    check_eq("accepted", acc_count != n0, 1);
    if (!hold) begin
      req_valid = 1'b0;
      req_addr  = 24'($urandom);
    end
  endtask

  task automatic wait_rsp(input int target);
    for (int i = 0; i < 4000 && rsp_count < target; i++) tick();
    check_eq("rsp_seen", rsp_count >= target, 1);
  endtask

  task automatic read_word(input logic [23:0] a);
    int r0;
    r0 = rsp_count;
    issue(a, 1'b0);
    wait_rsp(r0 + 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r0;
    int idle_bad;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'hEF;
    mem[1] = 8'hBE;
    mem[2] = 8'hAD;
    mem[3] = 8'hDE;

    rst = 1'b1;
    repeat (3) tick();
    check_eq("rst_req_ready", req_ready, 1);
    check_eq("rst_cs_n", spi_cs_n, 1);
    check_eq("rst_sck", spi_sck, 0);
    check_eq("rst_mosi", spi_mosi, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_data", rsp_data, 0);
    rst = 1'b0;
    tick();

    // Idle lines stay quiet
    idle_bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (spi_cs_n !== 1'b1 || spi_sck !== 1'b0 || spi_mosi !== 1'b0 ||
          req_ready !== 1'b1 || rsp_valid !== 1'b0) idle_bad++;
    end
    check_eq("idle_lines", idle_bad, 0);

    // Known word at 0x000100
    read_word(24'h000100);
    check_eq("deadbeef", last_rsp, 32'hDEADBEEF);
    check_eq("dir_latency", last_latency, DIR_LAT);

    // Back-to-back with the address changed mid-transfer
    r0 = rsp_count;
    issue(24'($urandom), 1'b1);
    repeat (40) tick();
    req_addr = 24'h000104;
    issue(24'h000104, 1'b0);
    wait_rsp(r0 + 2);

    // Reset in the middle of a frame
    r0 = rsp_count;
    issue(24'($urandom), 1'b0);
    for (int i = 0; i < 4000 && rises < 20; i++) tick();
    check_eq("reached_rise20", rises >= 20, 1);
    rst = 1'b1;
    tick();
    check_eq("abort_cs_n", spi_cs_n, 1);
    check_eq("abort_sck", spi_sck, 0);
    rst = 1'b0;
    tick();
    check_eq("abort_ready", req_ready, 1);
    repeat (300) tick();
    check_eq("abort_no_rsp", rsp_count - r0, 0);
    read_word(24'($urandom));

    // Reset wins over a simultaneous request
    rst = 1'b1;
    req_valid = 1'b1;
    req_addr = 24'($urandom);
    tick();
    check_eq("rst_prio_cs_n", spi_cs_n, 1);
    check_eq("rst_prio_ready", req_ready, 1);
    rst = 1'b0;
    req_valid = 1'b0;
    tick();
    check_eq("rst_prio_idle", spi_cs_n, 1);

    // Randomized reads, some spaced, some held back-to-back
    for (int t = 0; t < 12; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        r0 = rsp_count;
        issue(24'($urandom), 1'b1);
        issue(24'($urandom), 1'b0);
        wait_rsp(r0 + 2);
      end else begin
        read_word(24'($urandom));
      end
      repeat ($urandom_range(0, 3)) tick();
    end

    repeat (4 * CLK_DIV + 4) tick();
    check_eq("rsp_hold", hold_bad, 0);
    check_eq("final_idle", req_ready, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
